// File: rtl/curve25519_mock_pkg.sv
// Shared constants for the queued Curve25519 mock: known-answer table and engine states.
package curve25519_mock_pkg;

  localparam int KAT_COUNT = 3;
  localparam int KAT_W     = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The 64-digit literals carry a zero top bit; the cast drops it explicitly.
  localparam logic [KAT_W-1:0] KAT_N [KAT_COUNT] = '{
    {1'b1, 254'd0},
    255'(256'h4002030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20),
    255'(256'h4002030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20)
  };

  localparam logic [KAT_W-1:0] KAT_Q [KAT_COUNT] = '{
    255'd9,
    255'd9,
    255'(256'h71850c3f2cd59eac742ceea75fc37c5de912aded47b366629169d381bb9dfba6)
  };

  localparam logic [KAT_W-1:0] KAT_OUT [KAT_COUNT] = '{
    255'(256'h743bcb585f9990edc2cfc4af84f6ff300729bb5facda28154362cd47a37de52f),
    255'(256'h71850c3f2cd59eac742ceea75fc37c5de912aded47b366629169d381bb9dfba6),
    255'(256'h45dbaa45916a837457fdbda08bea49dbaabc29c65668ef235c7ae49a90375b54)
  };

endpackage

// File: rtl/curve25519_mock_queue_fifo.sv
// Request FIFO: power-of-two depth, pointers carry an extra wrap bit so
// full and empty are told apart without a separate count.
module mock_req_fifo #(
  parameter int WIDTH = 510,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop lands on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/curve25519_mock_queue.sv
// Queued Curve25519 scalar-multiply mock: FIFO of requests served one at a
// time with a fixed latency, answering from a known-answer table or echoing q.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | engine free; pops the FIFO head when one is waiting
// ST_BUSY | counting down the programmed latency
// ST_DONE | result presented, held until the consumer takes it
module curve25519_mock_queue
  import curve25519_mock_pkg::*;
#(
  parameter int WIDTH   = 255,
  parameter int LATENCY = 65535,
  parameter int DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_hit,
  output logic             busy
);

  // LATENCY=1 would give a zero-width counter; keep at least one bit.
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   work_n;
  logic [WIDTH-1:0]   work_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] fifo_rdata;
  logic               load;
  logic               finish;
  logic               kat_hit;
  logic [WIDTH-1:0]   kat_out;

  mock_req_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .wdata ({n, q}),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the load (pop) and finish strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_BUSY;
          load      = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
          finish    = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Table lookup on the working registers; a miss echoes q.
  always_comb begin
    kat_hit = 1'b0;
    kat_out = work_q;
    for (int i = 0; i < KAT_COUNT; i++) begin
      if (!kat_hit && work_n == WIDTH'(KAT_N[i]) && work_q == WIDTH'(KAT_Q[i])) begin
        kat_hit = 1'b1;
        kat_out = WIDTH'(KAT_OUT[i]);
      end
    end
  end

  // Working registers, latency down-counter and the held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      work_n  <= '0;
      work_q  <= '0;
      out     <= '0;
      out_hit <= 1'b0;
    end else begin
      if (load) begin
        {work_n, work_q} <= fifo_rdata;
        cnt              <= CNT_LOAD;
      end else if (state == ST_BUSY && cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (finish) begin
        out     <= kat_out;
        out_hit <= kat_hit;
      end
    end
  end

endmodule

// File: tb/tb_curve25519_mock_queue.sv
// Bench for curve25519_mock_queue: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_curve25519_mock_queue;

  localparam int W = 255;
  localparam int L = 4;
  localparam int D = 2;

  localparam logic [W-1:0] V1N = {1'b1, 254'd0};
  localparam logic [W-1:0] V1O = 255'(256'h743bcb585f9990edc2cfc4af84f6ff300729bb5facda28154362cd47a37de52f);
  localparam logic [W-1:0] V2N = 255'(256'h4002030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20);
  localparam logic [W-1:0] V2O = 255'(256'h71850c3f2cd59eac742ceea75fc37c5de912aded47b366629169d381bb9dfba6);
  localparam logic [W-1:0] V3O = 255'(256'h45dbaa45916a837457fdbda08bea49dbaabc29c65668ef235c7ae49a90375b54);
  localparam logic [W-1:0] NINE = 255'd9;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] n = '0;
  logic [W-1:0] q = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_hit;
  logic         busy;
  logic [W-1:0] out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [W-1:0] n;
    logic [W-1:0] q;
  } req_t;

  // Reference model: pending requests, the one in service, its remaining time.
  req_t         mq [$];
  req_t         m_req;
  bit           m_active = 0;
  bit           m_valid  = 0;
  int           m_rem    = 0;
  logic [W-1:0] e_out    = '0;
  logic         e_hit    = 1'b0;

  always #5 clock = ~clock;

  curve25519_mock_queue #(
    .WIDTH   (W),
    .LATENCY (L),
    .DEPTH   (D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hit   (out_hit),
    .busy      (busy)
  );

  function automatic void ref_kat(input req_t r, output logic [W-1:0] o, output logic h);
    h = 1'b1;
    if (r.n == V1N && r.q == NINE)      o = V1O;
    else if (r.n == V2N && r.q == NINE) o = V2O;
    else if (r.n == V2N && r.q == V2O)  o = V3O;
    else begin
      o = r.q;
      h = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic step(input logic iv, input logic [W-1:0] nn, input logic [W-1:0] qq,
                      input logic ordy, input logic rst, output bit acc);
    int sz0;
    reset     = rst;
    in_valid  = iv;
    n         = nn;
    q         = qq;
    out_ready = ordy;
    @(posedge clock);
    cyc++;
    acc = 0;
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_valid  = 0;
      m_rem    = 0;
      e_out    = '0;
      e_hit    = 1'b0;
    end else begin
      sz0 = mq.size();
      acc = iv && (sz0 < D);
      if (m_valid) begin
        if (ordy) begin
          m_valid  = 0;
          m_active = 0;
        end
      end else if (m_active) begin
        m_rem--;
        if (m_rem == 0) begin
          m_valid = 1;
          ref_kat(m_req, e_out, e_hit);
        end
      end else if (sz0 > 0) begin
        m_req    = mq.pop_front();
        m_active = 1;
        m_rem    = L;
      end
      if (acc) mq.push_back('{n: nn, q: qq});
    end
    #1;
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("in_ready",  W'(in_ready),  W'(mq.size() < D));
    chk("busy",      W'(busy),      W'(m_active || mq.size() != 0));
    chk("out",       out,           e_out);
    chk("out_hit",   W'(out_hit),   W'(e_hit));
  endtask

  initial begin
    bit           acc;
    bit           prev;
    int           k;
    int           t;
    int           t1;
    int           t2;
    int           idx;
    int           sel;
    req_t         r4 [4];
    logic [W-1:0] rn;
    logic [W-1:0] rq;

    // Reset state.
    step(0, '0, '0, 0, 1, acc);
    step(0, '0, '0, 0, 1, acc);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));

    // KAT vector 1 and its latency from acceptance.
    step(1, V1N, NINE, 0, 0, acc);
    k = 0;
    while (!out_valid && k < 50) begin
      step(0, '0, '0, 0, 0, acc);
      k++;
    end
    chk("lat_kat1", W'(k), W'(L + 1));
    chk("kat1_out", out, V1O);
    chk("kat1_hit", W'(out_hit), W'(1));
    step(0, '0, '0, 1, 0, acc);

    // Miss: q passes through with the same latency.
    step(1, W'(5), W'(16'h1234), 0, 0, acc);
    k = 0;
    while (!out_valid && k < 50) begin
      step(0, '0, '0, 0, 0, acc);
      k++;
    end
    chk("lat_miss", W'(k), W'(L + 1));
    chk("miss_out", out, W'(16'h1234));
    chk("miss_hit", W'(out_hit), W'(0));
    step(0, '0, '0, 1, 0, acc);

    // Back-pressure: four requests with the consumer stalled.
    for (int i = 0; i < 4; i++) r4[i] = '{n: rnd(), q: rnd()};
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      step(idx < 4, r4[(idx < 4) ? idx : 0].n, r4[(idx < 4) ? idx : 0].q, c >= 15, 0, acc);
      if (acc) idx++;
      if (c == 10) chk("held_off", W'(in_ready), W'(0));
    end
    k = 0;
    while ((busy || out_valid) && k < 100) begin
      step(0, '0, '0, 1, 0, acc);
      k++;
    end
    chk("drain_bp", W'(busy), W'(0));

    // Chained KAT vectors 2 and 3; the second push coincides with the first pop.
    step(1, V2N, NINE, 1, 0, acc);
    step(1, V2N, V2O, 1, 0, acc);
    t = 0; t1 = -1; t2 = -1; prev = 0;
    while (t < 40 && t2 < 0) begin
      step(0, '0, '0, 1, 0, acc);
      t++;
      if (out_valid && !prev) begin
        if (t1 < 0) begin
          t1 = t;
          chk("chain_first", out, V2O);
        end else begin
          t2 = t;
          chk("chain_second", out, V3O);
        end
      end
      prev = out_valid;
    end
    chk("chain_gap", W'(t2 - t1), W'(L + 2));

    // Reset while busy with one entry queued.
    step(1, V1N, NINE, 0, 0, acc);
    step(1, rnd(), rnd(), 0, 0, acc);
    step(0, '0, '0, 0, 0, acc);
    step(0, '0, '0, 0, 1, acc);
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 12; i++) step(0, '0, '0, 1, 0, acc);

    // Random traffic mixing table hits, near misses and random values.
    for (int c = 0; c < 500; c++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       begin rn = V1N; rq = NINE; end
        1:       begin rn = V2N; rq = NINE; end
        2:       begin rn = V2N; rq = V2O;  end
        3:       begin rn = V1N; rq = rnd(); end
        default: begin rn = rnd(); rq = rnd(); end
      endcase
      step($urandom_range(0, 2) != 0, rn, rq, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) == 0, acc);
    end

    k = 0;
    while ((busy || out_valid) && k < 100) begin
      step(0, '0, '0, 1, 0, acc);
      k++;
    end
    chk("final_idle", W'(busy), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
